// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Bit counter width for an N-bit word; N >= 2 keeps this at least 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Saturating bit counter with synchronous clear and terminal-count flag at N-1.
module piso_serializer_bit_counter #(
  parameter int unsigned N     = 8,
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             enable,
  output logic [Width-1:0] count,
  output logic             term
);

  localparam logic [Width-1:0] Last = Width'(N - 1);

  logic [Width-1:0] count_q, count_d;

  assign term  = (count_q == Last);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !term) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// N-bit parallel-in, LSB-first serial-out shifter with valid/ready load handshake.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         frame_done,
  output logic         busy
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [CntW-1:0] cnt;
  logic            term;
  logic            accept;
  logic            cnt_clear;
  logic            cnt_enable;

  piso_serializer_bit_counter #(
    .N     (N),
    .Width (CntW)
  ) u_bit_counter (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (cnt),
    .term    (term)
  );

  logic unused_cnt;
  assign unused_cnt = ^cnt;

  assign accept = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    load_ready   = 1'b1;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clear = 1'b1;
        if (accept) begin
          state_d = StShift;
          shift_d = data_in;
        end
      end
      StShift: begin
        serial_out   = shift_q[0];
        serial_valid = 1'b1;
        busy         = 1'b1;
        load_ready   = term;
        frame_done   = term;
        if (term) begin
          cnt_clear = 1'b1;
          if (accept) begin
            // Reload in the last-bit cycle keeps back-to-back words gapless.
            shift_d = data_in;
          end else begin
            state_d = StIdle;
            shift_d = '0;
          end
        end else begin
          cnt_enable = 1'b1;
          shift_d    = {1'b0, shift_q[N-1:1]};
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter N, default 8; serial word width in bits; legal range N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  N  parallel word; sampled only on an accepted load.
REQ-005 load_valid  input  1  upstream offers data_in this cycle.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 serial_out  output  1  serial data bit, LSB first.
REQ-008 serial_valid  output  1  serial_out carries a payload bit this cycle.
REQ-009 frame_done  output  1  one-cycle pulse in the cycle the last bit (bit N-1) is driven.
REQ-010 busy  output  1  a word is being shifted out.

Function
REQ-011 Accept = load_valid && load_ready at a rising clk edge; no other event loads data_in.
REQ-012 FSM states: IDLE and SHIFT.
REQ-013 In IDLE: load_ready=1, serial_valid=0, busy=0, frame_done=0, serial_out=0.
REQ-014 IDLE to SHIFT on accept: shift register <= data_in, bit counter <= 0.
REQ-015 In SHIFT: serial_out = shift register bit 0, serial_valid=1, busy=1.
REQ-016 Latency: bit 0 of an accepted word appears on serial_out in the first cycle after the accepting edge.
REQ-017 Each SHIFT-cycle edge without reload: shift register shifts right by one with 0 fill at the MSB, and the counter increments.
REQ-018 The counter is $clog2(N) bits wide; it counts 0..N-1 and never wraps past N-1.
REQ-019 In SHIFT, load_ready=0 while counter < N-1; load_ready=1 and frame_done=1 when counter == N-1.
REQ-020 Last-bit cycle with accept: reload data_in, counter <= 0, stay in SHIFT; back-to-back words produce gapless output (one word per N cycles).
REQ-021 Last-bit cycle without accept: return to IDLE.
REQ-022 In SHIFT, load_valid and data_in changes while load_ready=0 have no effect; the current word is neither corrupted nor truncated.
REQ-023 serial_valid is high for exactly N cycles per accepted word.
REQ-024 frame_done is high in exactly one cycle per word.

Reset
REQ-025 When n_reset is asserted, all state clears immediately, independent of clk: FSM=IDLE, shift register=0, counter=0.
REQ-026 During and after reset, outputs take the REQ-013 values: load_ready=1, serial_out=0, serial_valid=0, frame_done=0, busy=0.
REQ-027 Reset asserted mid-frame aborts the word; no residual bits are emitted after release.
REQ-028 The first accept after reset release is honoured on the first rising edge at which n_reset is high.

Structure
REQ-029 A shared package holds the FSM state encoding constants (IDLE, SHIFT) and the counter-width expression ($clog2(N)).
REQ-030 One sub-module is natural: bit_counter, a parameterised counter with clear, enable and terminal-count (== N-1) output.
REQ-031 The shift register, the FSM and the output decode are implemented in piso_serializer itself.

Verification (N=8)
REQ-032 After reset, load 8'hA5 once: serial_out = 1,0,1,0,0,1,0,1 over 8 cycles, serial_valid high for 8 cycles, frame_done in cycle 8, then IDLE.
REQ-033 Back-to-back: 8'h01 held with load_valid=1, then 8'h80 offered in the last-bit cycle: 16 gapless valid bits (1,0x7, then 0x7,1), two frame_done pulses 8 cycles apart.
REQ-034 Mid-frame interference: load 8'h3C, then toggle load_valid and change data_in to 8'hFF during bits 1..6: output remains exactly 8'h3C LSB-first.
REQ-035 Reset mid-frame: assert n_reset off the clock edge during bit 4 of 8'hFF: outputs reach reset values immediately; after release, no bits until a new accept.
REQ-036 Loopback: feed serial_out (gated by serial_valid) into a bench serial-in, right-shifting 8-bit capture register for 100 random words: the captured value equals each accepted word after its frame_done.
